// File: rtl/piso_pkg.sv
// Shared encodings for the PISO serializer: FSM states and per-word bit order.
package piso_pkg;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE  = STATE_IDLE,
    ST_SHIFT = STATE_SHIFT
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-side handshake and serial-side signals of the PISO serializer.
interface piso_serializer_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] Parallel_Data_In;
  logic                  Data_Valid_In;
  logic                  Lsb_First_In;
  logic                  Data_Ready_Out;
  logic                  Shift_En_In;
  logic                  Serial_Data_Out;
  logic                  Serial_Valid_Out;
  logic                  Frame_Last_Out;
  logic                  Busy_Out;
  logic [DATA_WIDTH-1:0] PISO_Shift_Register;

  modport master (
    output Parallel_Data_In, Data_Valid_In, Lsb_First_In, Shift_En_In,
    input  Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Frame_Last_Out,
    input  Busy_Out, PISO_Shift_Register
  );

  modport slave (
    input  Parallel_Data_In, Data_Valid_In, Lsb_First_In, Shift_En_In,
    output Data_Ready_Out, Serial_Data_Out, Serial_Valid_Out, Frame_Last_Out,
    output Busy_Out, PISO_Shift_Register
  );

endinterface

// File: rtl/piso_hold_buffer.sv
// One-entry holding register (word + bit order) that lets the next frame
// follow the current one with no idle gap.
module piso_hold_buffer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_sys,
  input  logic                  rst_b,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_order,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_order,
  output logic                  full
);

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      rd_data  <= '0;
      rd_order <= MSB_FIRST;
      full     <= 1'b0;
    end else begin
      if (wr) begin
        rd_data  <= wr_data;
        rd_order <= wr_order;
      end
      // A read and a write on the same edge leave the buffer occupied.
      if (wr)
        full <= 1'b1;
      else if (rd)
        full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with a valid/ready word
// input, per-word bit order, shift stall and frame markers.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no frame on the link; waiting for a word
// ST_SHIFT | a frame bit is on Serial_Data_Out; advances on Shift_En_In
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic              Clk_In,
  input logic              Reset_n_In,
  piso_serializer_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d, sreg_shift;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  order_q, order_d;

  logic                  hold_wr, hold_rd, hold_full, hold_order;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  accept, consume;

  piso_hold_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk_sys  (Clk_In),
    .rst_b    (Reset_n_In),
    .wr       (hold_wr),
    .rd       (hold_rd),
    .wr_data  (bus.Parallel_Data_In),
    .wr_order (bus.Lsb_First_In),
    .rd_data  (hold_data),
    .rd_order (hold_order),
    .full     (hold_full)
  );

  assign accept     = bus.Data_Valid_In && !hold_full;
  assign consume    = (state_q == ST_SHIFT) && bus.Shift_En_In;
  assign sreg_shift = (order_q == LSB_FIRST) ? (sreg_q >> 1) : (sreg_q << 1);

  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      order_q <= MSB_FIRST;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    order_d = order_q;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full) begin
          sreg_d  = hold_data;
          order_d = hold_order;
          hold_rd = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else if (accept) begin
          sreg_d  = bus.Parallel_Data_In;
          order_d = bus.Lsb_First_In;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Mid-frame accepts park in the hold buffer unless taken directly below.
        hold_wr = accept;
        if (consume) begin
          if (cnt_q != LAST_BIT) begin
            sreg_d = sreg_shift;
            cnt_d  = cnt_q + 1'b1;
          end else if (hold_full) begin
            sreg_d  = hold_data;
            order_d = hold_order;
            hold_rd = 1'b1;
            cnt_d   = '0;
          end else if (accept) begin
            sreg_d  = bus.Parallel_Data_In;
            order_d = bus.Lsb_First_In;
            hold_wr = 1'b0;
            cnt_d   = '0;
          end else begin
            sreg_d  = sreg_shift;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Data_Ready_Out      = !hold_full;
  assign bus.Serial_Valid_Out    = (state_q == ST_SHIFT);
  assign bus.Serial_Data_Out     = (state_q == ST_SHIFT) &&
                                   ((order_q == LSB_FIRST) ? sreg_q[0] : sreg_q[DATA_WIDTH-1]);
  assign bus.Frame_Last_Out      = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
  assign bus.Busy_Out            = (state_q == ST_SHIFT) || hold_full;
  assign bus.PISO_Shift_Register = sreg_q;

endmodule
